// File: rtl/seven_seg_pkg.sv
// Shared constants and types for the four-digit multiplexed seven-segment driver.
package seven_seg_pkg;
  localparam int NUM_DIGITS      = 4;
  localparam int DEF_REFRESH_DIV = 100000;
  localparam int DEF_GUARD       = 2;

  typedef logic [1:0] digit_idx_t;
endpackage

// File: rtl/seven_seg_4dig_mux_dec.sv
// Single-digit hex to seven-segment decoder; segments = {g,f,e,d,c,b,a}, active-high.
module SevenSeg1Dig
  import seven_seg_pkg::*;
(
  input  logic [3:0] binary,
  output logic [6:0] segments
);
  always_comb begin
    segments = 7'h00;
    case (binary)
      4'h0: segments = 7'h3F;
      4'h1: segments = 7'h06;
      4'h2: segments = 7'h5B;
      4'h3: segments = 7'h4F;
      4'h4: segments = 7'h66;
      4'h5: segments = 7'h6D;
      4'h6: segments = 7'h7D;
      4'h7: segments = 7'h07;
      4'h8: segments = 7'h7F;
      4'h9: segments = 7'h6F;
      4'hA: segments = 7'h77;
      4'hB: segments = 7'h7C;
      4'hC: segments = 7'h39;
      4'hD: segments = 7'h5E;
      4'hE: segments = 7'h79;
      4'hF: segments = 7'h71;
      default: segments = 7'h00;
    endcase
  end
endmodule

// File: rtl/seven_seg_4dig_mux.sv
// Four-digit time-multiplexed seven-segment driver with guard band and
// frame-synchronous (tear-free) display updates.
module seven_seg_4dig_mux
  import seven_seg_pkg::*;
#(
  parameter int REFRESH_DIV = DEF_REFRESH_DIV,
  parameter int GUARD       = DEF_GUARD
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] value_in,
  input  logic [3:0]  dp_in,
  input  logic [3:0]  blank_in,
  input  logic        load,
  output logic [6:0]  segments,
  output logic        dp_n,
  output logic [3:0]  an_n,
  output logic        busy
);
  localparam int PW = $clog2(REFRESH_DIV);

  logic [PW-1:0] r_presc, w_presc_nxt;
  digit_idx_t    r_idx, w_idx_nxt;
  logic [15:0]   r_disp_val, r_pend_val, w_disp_val_nxt;
  logic [3:0]    r_disp_dp, r_pend_dp, w_disp_dp_nxt;
  logic [3:0]    r_disp_blank, r_pend_blank, w_disp_blank_nxt;
  logic          r_busy, w_busy_nxt;
  logic [3:0]    r_an_n, w_an_n_nxt;
  logic          r_dp_n, w_dp_n_nxt;
  logic [3:0]    r_nibble, w_nibble_nxt;
  logic          w_tick, w_frame, w_guard_nxt;

  assign w_tick  = (r_presc == PW'(REFRESH_DIV - 1));
  assign w_frame = w_tick && (r_idx == 2'd3);

  // Output flops are loaded from next-cycle state so an_n/dp_n/nibble line up
  // with the prescaler and index they describe.
  always_comb begin
    w_presc_nxt      = w_tick ? '0 : r_presc + 1'b1;
    w_idx_nxt        = w_tick ? r_idx + 2'd1 : r_idx;
    w_disp_val_nxt   = r_disp_val;
    w_disp_dp_nxt    = r_disp_dp;
    w_disp_blank_nxt = r_disp_blank;
    w_busy_nxt       = r_busy;
    if (w_frame) begin
      w_busy_nxt = 1'b0;
      if (load) begin
        w_disp_val_nxt   = value_in;
        w_disp_dp_nxt    = dp_in;
        w_disp_blank_nxt = blank_in;
      end else if (r_busy) begin
        w_disp_val_nxt   = r_pend_val;
        w_disp_dp_nxt    = r_pend_dp;
        w_disp_blank_nxt = r_pend_blank;
      end
    end else if (load) begin
      w_busy_nxt = 1'b1;
    end
    w_guard_nxt  = (w_presc_nxt < PW'(GUARD));
    w_nibble_nxt = 4'(w_disp_val_nxt >> {w_idx_nxt, 2'b00});
    if (w_guard_nxt || w_disp_blank_nxt[w_idx_nxt]) begin
      w_an_n_nxt = 4'b1111;
      w_dp_n_nxt = 1'b1;
    end else begin
      w_an_n_nxt = ~(4'b0001 << w_idx_nxt);
      w_dp_n_nxt = ~w_disp_dp_nxt[w_idx_nxt];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_presc      <= '0;
      r_idx        <= '0;
      r_disp_val   <= '0;
      r_disp_dp    <= '0;
      r_disp_blank <= '0;
      r_pend_val   <= '0;
      r_pend_dp    <= '0;
      r_pend_blank <= '0;
      r_busy       <= 1'b0;
      r_an_n       <= 4'b1111;
      r_dp_n       <= 1'b1;
      r_nibble     <= '0;
    end else begin
      r_presc      <= w_presc_nxt;
      r_idx        <= w_idx_nxt;
      r_disp_val   <= w_disp_val_nxt;
      r_disp_dp    <= w_disp_dp_nxt;
      r_disp_blank <= w_disp_blank_nxt;
      r_busy       <= w_busy_nxt;
      r_an_n       <= w_an_n_nxt;
      r_dp_n       <= w_dp_n_nxt;
      r_nibble     <= w_nibble_nxt;
      if (load) begin
        r_pend_val   <= value_in;
        r_pend_dp    <= dp_in;
        r_pend_blank <= blank_in;
      end
    end
  end

  SevenSeg1Dig u_dec (
    .binary   (r_nibble),
    .segments (segments)
  );

  assign an_n = r_an_n;
  assign dp_n = r_dp_n;
  assign busy = r_busy;
endmodule

// File: tb/tb_seven_seg_4dig_mux.sv
// Directed bench for seven_seg_4dig_mux with a cycle-count display model.
module tb_seven_seg_4dig_mux;
  localparam int DIV = 8;
  localparam int GRD = 2;
  localparam logic [6:0] SEG_TAB [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                          7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] value_in = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  blank_in = '0;
  logic        load = 1'b0;
  logic [6:0]  segments;
  logic        dp_n;
  logic [3:0]  an_n;
  logic        busy;

  int n_vec = 0;
  int n_fail = 0;

  seven_seg_4dig_mux #(.REFRESH_DIV(DIV), .GUARD(GRD)) dut (
    .clk(clk), .rst_n(rst_n), .value_in(value_in), .dp_in(dp_in), .blank_in(blank_in),
    .load(load), .segments(segments), .dp_n(dp_n), .an_n(an_n), .busy(busy)
  );

  always #5 clk = ~clk;

  // Model: m_cnt = clk cycles since reset release; everything else follows from it.
  int          m_cnt = 0;
  bit          m_valid = 1'b0;
  logic [15:0] m_val, p_val;
  logic [3:0]  m_dp, p_dp, m_blank, p_blank;
  logic        m_busy;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_cnt = 0; m_valid = 1'b1;
      m_val = '0; m_dp = '0; m_blank = '0;
      p_val = '0; p_dp = '0; p_blank = '0; m_busy = 1'b0;
    end else begin
      if ((m_cnt % (DIV * 4)) == DIV * 4 - 1) begin
        if (load) begin
          m_val = value_in; m_dp = dp_in; m_blank = blank_in;
        end else if (m_busy) begin
          m_val = p_val; m_dp = p_dp; m_blank = p_blank;
        end
        m_busy = 1'b0;
      end else if (load) begin
        m_busy = 1'b1;
      end
      if (load) begin
        p_val = value_in; p_dp = dp_in; p_blank = blank_in;
      end
      m_cnt++;
    end
  end

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h expected %h", nm, m_cnt, act, exp);
    end
  endtask

  int       c_pos, c_dig;
  logic [3:0] c_an;
  logic       c_dp;
  always @(negedge clk) begin
    if (m_valid) begin
      c_pos = m_cnt % DIV;
      c_dig = (m_cnt / DIV) % 4;
      if (c_pos < GRD || m_blank[c_dig]) begin
        c_an = 4'b1111; c_dp = 1'b1;
      end else begin
        c_an = ~(4'b0001 << c_dig); c_dp = ~m_dp[c_dig];
      end
      chk("an_n", {12'h0, an_n}, {12'h0, c_an});
      chk("dp_n", {15'h0, dp_n}, {15'h0, c_dp});
      chk("busy", {15'h0, busy}, {15'h0, m_busy});
      if (c_an != 4'b1111)
        chk("segments", {9'h0, segments}, {9'h0, SEG_TAB[(m_val >> (4 * c_dig)) & 16'hF]});
    end
  end

  task automatic go_to(input int target);
    int n = 0;
    while (m_cnt != target && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (m_cnt != target) chk("go_to_timeout", 16'(m_cnt), 16'(target));
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] dp, input logic [3:0] bl);
    value_in = v; dp_in = dp; blank_in = bl; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("lit_reset_an", {12'h0, an_n}, 16'h000F);
    chk("lit_reset_busy", {15'h0, busy}, 16'h0);
    go_to(2);
    chk("lit_first_drive_an", {12'h0, an_n}, 16'h000E);
    chk("lit_first_drive_seg", {9'h0, segments}, 16'h003F);
    go_to(40);
    do_load(16'h1A3F, 4'h0, 4'h0);
    chk("lit_busy_set", {15'h0, busy}, 16'h1);
    go_to(66);
    chk("lit_1A3F_d0", {9'h0, segments}, 16'h0071);
    go_to(90);
    chk("lit_1A3F_d3_an", {12'h0, an_n}, 16'h0007);
    chk("lit_1A3F_d3", {9'h0, segments}, 16'h0006);
    go_to(100);
    do_load(16'h1111, 4'h0, 4'h0);
    go_to(110);
    do_load(16'h2222, 4'h0, 4'h0);
    go_to(130);
    chk("lit_2222_d0", {9'h0, segments}, 16'h005B);
    go_to(159);
    do_load(16'hBEEF, 4'h0, 4'h0);
    chk("lit_direct_busy", {15'h0, busy}, 16'h0);
    go_to(162);
    chk("lit_BEEF_d0", {9'h0, segments}, 16'h0071);
    go_to(170);
    do_load(16'h1234, 4'b0001, 4'b1010);
    go_to(178);
    chk("lit_BEEF_d2", {9'h0, segments}, 16'h0079);
    go_to(194);
    chk("lit_dp_d0", {15'h0, dp_n}, 16'h0);
    chk("lit_1234_d0", {9'h0, segments}, 16'h0066);
    go_to(202);
    chk("lit_blank_d1", {12'h0, an_n}, 16'h000F);
    go_to(210);
    chk("lit_d2_an", {12'h0, an_n}, 16'h000B);
    chk("lit_d2_dp", {15'h0, dp_n}, 16'h1);
    go_to(230);
    do_load(16'h5555, 4'hF, 4'h0);
    go_to(235);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("lit_rst_an", {12'h0, an_n}, 16'h000F);
    chk("lit_rst_busy", {15'h0, busy}, 16'h0);
    go_to(2);
    chk("lit_rst_seg", {9'h0, segments}, 16'h003F);
    go_to(40);
    chk("lit_rst_lost", {9'h0, segments}, 16'h003F);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
